// File: rtl/sub_seq.sv
// sub_seq: four-cycle sequential 5-operand subtractor with borrow-in.
// Ports: clk, rst, start, operand1..5, bin -> busy, done, result, bout, ovf.
module sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [31:0] operand3,
  input  logic [31:0] operand4,
  input  logic [31:0] operand5,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        bout,
  output logic        ovf
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       k_q, k_d;
  logic [35:0]      uacc_q, uacc_d;
  logic [35:0]      sacc_q, sacc_d;
  logic [3:0][31:0] q_q, q_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      res_q, res_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      sub_sel;
  logic [35:0]      uacc_nx;
  logic [35:0]      sacc_nx;
  logic [35:0]      bin_x;

  // One shared 36-bit step: the unsigned path zero-extends, the signed
  // path sign-extends the same latched subtrahend.
  always_comb begin
    sub_sel = q_q[k_q];
    bin_x   = {35'd0, bin};
    uacc_nx = uacc_q - {4'd0, sub_sel};
    sacc_nx = sacc_q - {{4{sub_sel[31]}}, sub_sel};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    uacc_d  = uacc_q;
    sacc_d  = sacc_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d[0]  = operand2;
          q_d[1]  = operand3;
          q_d[2]  = operand4;
          q_d[3]  = operand5;
          uacc_d  = {4'd0, operand1} - bin_x;
          sacc_d  = {{4{operand1[31]}}, operand1} - bin_x;
          k_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        uacc_d = uacc_nx;
        sacc_d = sacc_nx;
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) begin
          res_d   = uacc_nx[31:0];
          // Exact value is negative iff the 36-bit unsigned path is.
          bout_d  = uacc_nx[35];
          // Fits in 32-bit signed only if bits 35..31 all agree.
          ovf_d   = !((sacc_nx[35:31] == 5'b00000) ||
                      (sacc_nx[35:31] == 5'b11111));
          done_d  = 1'b1;
          busy_d  = 1'b0;
          k_d     = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        k_d     = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      uacc_q  <= 36'd0;
      sacc_q  <= 36'd0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 32'd0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      uacc_q  <= uacc_d;
      sacc_q  <= sacc_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign bout   = bout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sub_seq.sv
// tb_sub_seq: scoreboard bench for sub_seq.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_sub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] operand1, operand2, operand3, operand4, operand5;
  logic        bin;
  logic        busy, done, bout, ovf;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        bo;
    logic        ov;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t sb[$];
  chk_t dq[$];

  int total;
  int bad;

  sub_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .operand1(operand1),
    .operand2(operand2),
    .operand3(operand3),
    .operand4(operand4),
    .operand5(operand5),
    .bin(bin),
    .busy(busy),
    .done(done),
    .result(result),
    .bout(bout),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(string n, logic [31:0] a,
                              logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        cmp("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        cmp("result", result, e.res);
        cmp("bout", {31'd0, bout}, {31'd0, e.bo});
        cmp("ovf", {31'd0, ovf}, {31'd0, e.ov});
      end
    end
    cmp("busy_done_excl", {31'd0, busy & done}, 32'd0);
    while (dq.size() > 0) begin
      c = dq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  task automatic post(input string n, input logic [31:0] a,
                      input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    dq.push_back(c);
  endtask

  task automatic drive(input logic [31:0] a, b, c, d, e,
                       input logic bi);
    operand1 = a;
    operand2 = b;
    operand3 = c;
    operand4 = d;
    operand5 = e;
    bin      = bi;
  endtask

  // now=1: drive immediately (e.g. inside a done cycle).
  // junk=1: after acceptance, change operands and pulse start.
  task automatic issue(input logic [31:0] a, b, c, d, e,
                       input logic bi,
                       input logic [31:0] xr,
                       input logic xb, xo,
                       input bit now, input bit junk);
    exp_t x;
    int   n;
    int   bc;
    if (!now) @(negedge clk);
    drive(a, b, c, d, e, bi);
    start = 1'b1;
    x.res = xr;
    x.bo  = xb;
    x.ov  = xo;
    sb.push_back(x);
    @(posedge clk);
    #1;
    post("busy_after_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    if (junk) begin
      drive(~a, 32'd7, 32'd7, 32'd7, 32'd7, ~bi);
      start = 1'b1;
    end
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 12) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
    end
    post("latency", n, 32'd4);
    post("busy_cycles", bc, 32'd4);
    post("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    post("rst_busy", {31'd0, busy}, 32'd0);
    post("rst_done", {31'd0, done}, 32'd0);
    post("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(32'd100, 32'd10, 32'd20, 32'd30, 32'd5, 1'b0,
          32'd35, 1'b0, 1'b0, 0, 0);
    issue(32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1,
          32'hFFFF_FFFE, 1'b1, 1'b0, 0, 0);
    issue(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
          32'h0000_0003, 1'b1, 1'b0, 0, 0);
    issue(32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0,
          32'h7FFF_FFFF, 1'b0, 1'b1, 0, 0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0,
          32'h8000_0000, 1'b1, 1'b1, 0, 0);
    issue(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0,
          32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);

    // Busy-time start with new operands is ignored.
    issue(32'h1234_5678, 32'h1000, 32'h200, 32'h30, 32'h4, 1'b1,
          32'h1234_4443, 1'b0, 1'b0, 0, 1);
    // Reassert start in the done cycle: accepted back-to-back.
    issue(32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 1'b1,
          32'd0, 1'b0, 1'b0, 1, 0);
    issue(32'd9, 32'd1, 32'd1, 32'd1, 32'd1, 1'b0,
          32'd5, 1'b0, 1'b0, 1, 0);

    // Abort at k=2 with an async reset between edges; no done follows.
    @(negedge clk);
    drive(32'hFFFF_0000, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    post("abort_busy", {31'd0, busy}, 32'd0);
    post("abort_done", {31'd0, done}, 32'd0);
    post("abort_result", result, 32'd0);
    post("abort_bout", {31'd0, bout}, 32'd0);
    post("abort_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    post("abort_no_done", {31'd0, done}, 32'd0);

    issue(32'd50, 32'd7, 32'd8, 32'd9, 32'd10, 1'b0,
          32'd16, 1'b0, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    post("sb_empty", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
